// File: rtl/fft_frame_loader_pkg.sv
// Shared parameters, write-FSM state type and the output word packer
// used by the FFT frame loader and its bench.
package fft_pkg;

  localparam int FRAME_LEN_DEF = 1024;
  localparam int OUT_W_DEF     = 16;
  localparam int PACK_MAX_W    = 32;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_FILL = 2'd1,
    WR_DROP = 2'd2
  } wr_state_e;

  // Real part: the already sign-extended sample truncated to out_w bits.
  // Imaginary part (bits out_w and up) stays zero.
  function automatic logic [2*PACK_MAX_W-1:0] pack_tdata(
    input logic signed [PACK_MAX_W-1:0] sample,
    input int                           out_w
  );
    logic [2*PACK_MAX_W-1:0] word;
    word = '0;
    for (int i = 0; i < PACK_MAX_W; i++) begin
      if (i < out_w) word[i] = sample[i];
    end
    return word;
  endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// AXI-Stream link from the frame loader to the FFT core data input.
interface fft_frame_loader_if #(
  parameter int OUT_W = 16
);
  logic [2*OUT_W-1:0] m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic               m_axis_tlast;

  modport master (
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/fft_frame_loader_ram.sv
// Two-bank sample store: simple dual-port, address {bank, addr},
// one-cycle registered read so it maps onto block RAM.
module pingpong_ram #(
  parameter  int DEPTH  = 2048,
  parameter  int DATA_W = 14,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/fft_frame_loader.sv
// Packs a sample stream into fixed-length frames in a ping-pong buffer
// and streams each complete frame to the FFT core with tlast on the final beat.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int DATA_W    = 14,
  parameter int OUT_W     = OUT_W_DEF
) (
  input  logic                     sclk,
  input  logic                     rst,
  input  logic                     capture_en,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     data_valid,
  fft_frame_loader_if.master       m_axis,
  output logic                     overflow,
  output logic [15:0]              frame_cnt
);

  localparam int AW = $clog2(FRAME_LEN);
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

  wr_state_e          wr_state_q;
  logic               wr_bank_q;
  logic [AW-1:0]      wr_addr_q;
  logic [1:0]         full_q;
  logic               overflow_q;

  logic               iss_bank_q;
  logic [AW-1:0]      iss_addr_q;
  logic               rvalid_q;
  logic               rlast_q;
  logic               rd_bank_q;
  logic [15:0]        frame_cnt_q;

  logic               head_valid_q, head_last_q;
  logic [2*OUT_W-1:0] head_data_q;
  logic               tail_valid_q, tail_last_q;
  logic [2*OUT_W-1:0] tail_data_q;

  logic               wr_en, wr_last, pop, push, iss_en;
  logic [1:0]         full_set, full_clr, full_d, full_kept;
  logic [1:0]         occ;
  logic [DATA_W-1:0]  ram_rdata;
  logic [2*OUT_W-1:0] rd_word;

  assign wr_en   = (wr_state_q == WR_FILL) && capture_en && data_valid;
  assign wr_last = (wr_addr_q == LAST_ADDR);
  assign pop     = head_valid_q && m_axis.m_axis_tready;
  assign push    = rvalid_q;

  // Per-bank flag update: a bank is set by the final write and cleared by the tlast handshake.
  for (genvar gi = 0; gi < 2; gi++) begin : g_full
    assign full_set[gi]  = wr_en && wr_last && (wr_bank_q == 1'(gi));
    assign full_clr[gi]  = pop && head_last_q && (rd_bank_q == 1'(gi));
    assign full_kept[gi] = full_q[gi] && !full_clr[gi];
    assign full_d[gi]    = full_kept[gi] || full_set[gi];
  end

  // Read credit counts the beat landing from RAM, so the 2-entry buffer never overfills.
  assign occ    = 2'(head_valid_q) + 2'(tail_valid_q) + 2'(rvalid_q);
  assign iss_en = full_q[iss_bank_q] && ((occ - 2'(pop)) < 2'd2);

  assign rd_word = (2*OUT_W)'(pack_tdata(PACK_MAX_W'(signed'(ram_rdata)), OUT_W));

  pingpong_ram #(
    .DEPTH  (2 * FRAME_LEN),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (sclk),
    .we_i    (wr_en),
    .waddr_i ({wr_bank_q, wr_addr_q}),
    .wdata_i (data_in),
    .re_i    (iss_en),
    .raddr_i ({iss_bank_q, iss_addr_q}),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      wr_bank_q  <= 1'b0;
      wr_addr_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= (wr_state_q == WR_DROP) && data_valid;
      case (wr_state_q)
        WR_IDLE: begin
          if (capture_en && !full_q[wr_bank_q]) begin
            wr_state_q <= WR_FILL;
            wr_addr_q  <= '0;
          end
        end
        WR_FILL: begin
          if (!capture_en) begin
            wr_state_q <= WR_IDLE;
            wr_addr_q  <= '0;
          end else if (data_valid) begin
            if (wr_last) begin
              wr_addr_q  <= '0;
              wr_bank_q  <= !wr_bank_q;
              wr_state_q <= full_kept[!wr_bank_q] ? WR_DROP : WR_FILL;
            end else begin
              wr_addr_q <= wr_addr_q + 1'b1;
            end
          end
        end
        WR_DROP: begin
          if (!capture_en) begin
            wr_state_q <= WR_IDLE;
            wr_addr_q  <= '0;
          end else if (!full_q[wr_bank_q]) begin
            wr_state_q <= WR_FILL;
            wr_addr_q  <= '0;
          end
        end
        default: begin
          wr_state_q <= WR_IDLE;
          wr_addr_q  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      full_q      <= 2'b00;
      iss_bank_q  <= 1'b0;
      iss_addr_q  <= '0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rd_bank_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      full_q   <= full_d;
      rvalid_q <= iss_en;
      rlast_q  <= iss_en && (iss_addr_q == LAST_ADDR);
      if (iss_en) begin
        if (iss_addr_q == LAST_ADDR) begin
          iss_addr_q <= '0;
          iss_bank_q <= !iss_bank_q;
        end else begin
          iss_addr_q <= iss_addr_q + 1'b1;
        end
      end
      if (pop && head_last_q) begin
        rd_bank_q   <= !rd_bank_q;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  // Head drives the bus and only moves on a handshake; tail catches the beat already in flight.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      head_valid_q <= 1'b0;
      head_last_q  <= 1'b0;
      head_data_q  <= '0;
      tail_valid_q <= 1'b0;
      tail_last_q  <= 1'b0;
      tail_data_q  <= '0;
    end else if (!head_valid_q || pop) begin
      if (tail_valid_q) begin
        head_valid_q <= 1'b1;
        head_last_q  <= tail_last_q;
        head_data_q  <= tail_data_q;
        tail_valid_q <= push;
        if (push) begin
          tail_last_q <= rlast_q;
          tail_data_q <= rd_word;
        end
      end else begin
        head_valid_q <= push;
        tail_valid_q <= 1'b0;
        if (push) begin
          head_last_q <= rlast_q;
          head_data_q <= rd_word;
        end
      end
    end else if (push) begin
      tail_valid_q <= 1'b1;
      tail_last_q  <= rlast_q;
      tail_data_q  <= rd_word;
    end
  end

  assign m_axis.m_axis_tvalid = head_valid_q;
  assign m_axis.m_axis_tlast  = head_valid_q && head_last_q;
  assign m_axis.m_axis_tdata  = head_data_q;
  assign overflow             = overflow_q;
  assign frame_cnt            = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Randomised bench for fft_frame_loader with FRAME_LEN=8: a queue model of
// accepted samples predicts every output beat, tlast position and frame count.
module tb_fft_frame_loader;

  localparam int FL = 8;
  localparam int DW = 14;
  localparam int OW = 16;

  typedef struct packed {
    logic [2*OW-1:0] data;
    logic            last;
  } beat_t;

  logic          sclk = 1'b0;
  logic          rst;
  logic          capture_en;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          overflow;
  logic [15:0]   frame_cnt;

  fft_frame_loader_if #(.OUT_W(OW)) axis_if ();

  fft_frame_loader #(
    .FRAME_LEN (FL),
    .DATA_W    (DW),
    .OUT_W     (OW)
  ) dut (
    .sclk       (sclk),
    .rst        (rst),
    .capture_en (capture_en),
    .data_in    (data_in),
    .data_valid (data_valid),
    .m_axis     (axis_if),
    .overflow   (overflow),
    .frame_cnt  (frame_cnt)
  );

  always #5 sclk = ~sclk;

  int    n_err = 0;
  int    n_chk = 0;
  beat_t exp_q[$];
  beat_t obs_q[$];
  int    acc_cnt;
  int    exp_frames;
  int    ovf_cnt;
  int    hold_err;
  int    rdy_mode = 0;  // 0: always ready, 1: never, 2: toggle, 3: random 75%

  logic          prev_stall = 1'b0;
  logic [2*OW-1:0] prev_data;
  logic          prev_last;

  always @(posedge sclk) begin
    #1;
    case (rdy_mode)
      0:       axis_if.m_axis_tready = 1'b1;
      1:       axis_if.m_axis_tready = 1'b0;
      2:       axis_if.m_axis_tready = ~axis_if.m_axis_tready;
      default: axis_if.m_axis_tready = ($urandom_range(3) != 0);
    endcase
  end

  // Recorder only: captures handshakes, overflow pulses and stall-hold breaches.
  always @(negedge sclk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!axis_if.m_axis_tvalid || axis_if.m_axis_tdata !== prev_data ||
                         axis_if.m_axis_tlast !== prev_last))
        hold_err++;
      if (axis_if.m_axis_tvalid && axis_if.m_axis_tready) begin
        beat_t b;
        b.data = axis_if.m_axis_tdata;
        b.last = axis_if.m_axis_tlast;
        obs_q.push_back(b);
      end
      if (overflow) ovf_cnt++;
      prev_stall = axis_if.m_axis_tvalid && !axis_if.m_axis_tready;
      prev_data  = axis_if.m_axis_tdata;
      prev_last  = axis_if.m_axis_tlast;
    end
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    ovf_cnt  = 0;
    hold_err = 0;
  endtask

  // Expected beat: sample as a signed 14-bit number, written as 16-bit two's complement.
  task automatic model_push(input logic [DW-1:0] v);
    beat_t b;
    int    sv;
    sv = int'(v);
    if (sv >= 8192) sv = sv - 16384;
    b.data = {16'h0000, 16'(sv)};
    b.last = (acc_cnt % FL) == FL - 1;
    acc_cnt++;
    if (b.last) exp_frames++;
    exp_q.push_back(b);
  endtask

  task automatic drive_sample(input logic [DW-1:0] v, input bit acc);
    data_in    = v;
    data_valid = 1'b1;
    if (acc) model_push(v);
    tick();
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; capture_en = 1'b0; data_valid = 1'b0; data_in = '0;
    acc_cnt = 0; exp_frames = 0;
    repeat (3) tick();
    n_chk++; if (axis_if.m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", axis_if.m_axis_tvalid); end
    n_chk++; if (axis_if.m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast: got %b want 0", axis_if.m_axis_tlast); end
    n_chk++; if (axis_if.m_axis_tdata !== 32'h0) begin n_err++; $display("FAIL reset_tdata: got %h want 0", axis_if.m_axis_tdata); end
    n_chk++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_chk++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    rst = 1'b0;
    tick();
    n_chk++; if (axis_if.m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL post_reset_tvalid: got %b want 0", axis_if.m_axis_tvalid); end
    capture_en = 1'b1;
    repeat (2) tick();
    $display("reset: done, capture enabled");
  endtask

  task automatic test_ramp();
    clear_sb();
    rdy_mode = 0;
    for (int i = 0; i < 2 * FL; i++) drive_sample(DW'(i), 1'b1);
    for (int c = 0; c < 400 && obs_q.size() < exp_q.size(); c++) tick();
    repeat (4) tick();
    n_chk++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL ramp_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ramp_beat %0d: got %h/%b want %h/%b", i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last); end
    end
    n_chk++; if (ovf_cnt != 0) begin n_err++; $display("FAIL ramp_overflow: got %0d pulses want 0", ovf_cnt); end
    n_chk++; if (frame_cnt !== 16'd2) begin n_err++; $display("FAIL ramp_frame_cnt: got %0d want 2", frame_cnt); end
    $display("ramp: %0d beats, frame_cnt=%0d", obs_q.size(), frame_cnt);
  endtask

  task automatic test_negative();
    clear_sb();
    rdy_mode = 0;
    drive_sample(14'h3FFB, 1'b1);
    for (int i = 1; i < FL; i++) drive_sample(DW'($urandom_range(16383)), 1'b1);
    for (int c = 0; c < 400 && obs_q.size() < exp_q.size(); c++) tick();
    repeat (4) tick();
    n_chk++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL neg_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    if (obs_q.size() > 0) begin
      n_chk++; if (obs_q[0].data !== 32'h0000_FFFB) begin n_err++; $display("FAIL neg_minus5: got %h want 0000fffb", obs_q[0].data); end
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL neg_beat %0d: got %h/%b want %h/%b", i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last); end
    end
    n_chk++; if (frame_cnt !== 16'(exp_frames)) begin n_err++; $display("FAIL neg_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    $display("negative: %0d beats, first=%h", obs_q.size(), obs_q.size() > 0 ? obs_q[0].data : 32'h0);
  endtask

  task automatic test_backpressure();
    clear_sb();
    rdy_mode = 2;
    for (int i = 0; i < 2 * FL; i++) drive_sample(DW'($urandom_range(16383)), 1'b1);
    for (int c = 0; c < 400 && obs_q.size() < exp_q.size(); c++) tick();
    repeat (4) tick();
    n_chk++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL bp_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_beat %0d: got %h/%b want %h/%b", i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last); end
    end
    n_chk++; if (hold_err != 0) begin n_err++; $display("FAIL bp_hold: got %0d stall changes want 0", hold_err); end
    n_chk++; if (ovf_cnt != 0) begin n_err++; $display("FAIL bp_overflow: got %0d pulses want 0", ovf_cnt); end
    n_chk++; if (frame_cnt !== 16'(exp_frames)) begin n_err++; $display("FAIL bp_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    $display("backpressure: %0d beats, frame_cnt=%0d", obs_q.size(), frame_cnt);
  endtask

  task automatic test_random();
    clear_sb();
    rdy_mode = 3;
    for (int i = 0; i < 5 * FL; i++) begin
      repeat ($urandom_range(3)) tick();
      drive_sample(DW'($urandom_range(16383)), 1'b1);
    end
    rdy_mode = 0;
    for (int c = 0; c < 400 && obs_q.size() < exp_q.size(); c++) tick();
    repeat (4) tick();
    n_chk++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_beat %0d: got %h/%b want %h/%b", i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last); end
    end
    n_chk++; if (hold_err != 0) begin n_err++; $display("FAIL rand_hold: got %0d stall changes want 0", hold_err); end
    n_chk++; if (ovf_cnt != 0) begin n_err++; $display("FAIL rand_overflow: got %0d pulses want 0", ovf_cnt); end
    n_chk++; if (frame_cnt !== 16'(exp_frames)) begin n_err++; $display("FAIL rand_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    $display("random: %0d beats, frame_cnt=%0d", obs_q.size(), frame_cnt);
  endtask

  task automatic test_overflow();
    clear_sb();
    rdy_mode = 1;
    repeat (2) tick();
    for (int i = 0; i < 30; i++) drive_sample(DW'($urandom_range(16383)), i < 2 * FL);
    repeat (2) tick();
    n_chk++; if (ovf_cnt != 14) begin n_err++; $display("FAIL ovf_pulses: got %0d want 14", ovf_cnt); end
    rdy_mode = 0;
    for (int c = 0; c < 400 && obs_q.size() < exp_q.size(); c++) tick();
    repeat (10) tick();
    for (int i = 0; i < FL; i++) drive_sample(DW'($urandom_range(16383)), 1'b1);
    for (int c = 0; c < 400 && obs_q.size() < exp_q.size(); c++) tick();
    repeat (4) tick();
    n_chk++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL ovf_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_beat %0d: got %h/%b want %h/%b", i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last); end
    end
    n_chk++; if (hold_err != 0) begin n_err++; $display("FAIL ovf_hold: got %0d stall changes want 0", hold_err); end
    n_chk++; if (ovf_cnt != 14) begin n_err++; $display("FAIL ovf_pulses_final: got %0d want 14", ovf_cnt); end
    n_chk++; if (frame_cnt !== 16'(exp_frames)) begin n_err++; $display("FAIL ovf_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    $display("overflow: %0d beats, %0d drops, frame_cnt=%0d", obs_q.size(), ovf_cnt, frame_cnt);
  endtask

  task automatic test_abort_reset();
    clear_sb();
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) drive_sample(DW'($urandom_range(16383)), 1'b0);
    capture_en = 1'b0;
    repeat (2) tick();
    capture_en = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < FL; i++) drive_sample(DW'($urandom_range(16383)), 1'b1);
    for (int c = 0; c < 400 && obs_q.size() < exp_q.size(); c++) tick();
    repeat (4) tick();
    n_chk++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL abort_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL abort_beat %0d: got %h/%b want %h/%b", i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last); end
    end
    n_chk++; if (frame_cnt !== 16'(exp_frames)) begin n_err++; $display("FAIL abort_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    $display("abort: %0d beats, frame_cnt=%0d", obs_q.size(), frame_cnt);

    // Stall a full frame on the bus, then hit reset in the middle of the cycle.
    rdy_mode = 1;
    repeat (2) tick();
    for (int i = 0; i < FL; i++) drive_sample(DW'($urandom_range(16383)), 1'b0);
    repeat (4) tick();
    n_chk++; if (axis_if.m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL stall_tvalid: got %b want 1", axis_if.m_axis_tvalid); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (axis_if.m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL async_rst_tvalid: got %b want 0", axis_if.m_axis_tvalid); end
    n_chk++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL async_rst_frame_cnt: got %0d want 0", frame_cnt); end
    clear_sb();
    acc_cnt = 0; exp_frames = 0;
    tick();
    rst = 1'b0;
    rdy_mode = 0;
    repeat (2) tick();
    for (int i = 0; i < FL; i++) drive_sample(DW'($urandom_range(16383)), 1'b1);
    for (int c = 0; c < 400 && obs_q.size() < exp_q.size(); c++) tick();
    repeat (4) tick();
    n_chk++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rst_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rst_beat %0d: got %h/%b want %h/%b", i, obs_q[i].data, obs_q[i].last, exp_q[i].data, exp_q[i].last); end
    end
    n_chk++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL rst_frame_cnt: got %0d want 1", frame_cnt); end
    $display("reset mid-stream: %0d beats, frame_cnt=%0d", obs_q.size(), frame_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axis_if.m_axis_tready = 1'b1;
    test_reset();
    test_ramp();
    test_negative();
    test_backpressure();
    test_random();
    test_overflow();
    test_abort_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fft_frame_loader.md
# fft_frame_loader

Receive-side counterpart of the DDS test-tone generator. Accepts the 14-bit signed sample stream on `sclk` and packs it into fixed-length frames in a ping-pong buffer. It then streams each frame to the FFT core's AXI-Stream data input with `tlast` on the final beat. While one bank is being filled, the other can be read, so a continuous input stream loses no samples as long as the FFT keeps pace.

## Interface
- `FRAME_LEN`, default 1024: samples per frame; power of 2, at least 4.
- `DATA_W`, default 14: input sample width, signed.
- `OUT_W`, default 16: per-component width in `m_axis_tdata`; must be at least `DATA_W`.
- `sclk`, in, 1: single clock for the whole block.
- `rst`, in, 1: asynchronous, active-high reset.
- `capture_en`, in, 1: framing enable. Sampled each cycle.
- `data_in`, in, `DATA_W`: signed sample.
- `data_valid`, in, 1: `data_in` is valid this cycle.
- `m_axis_tdata`, out, 2*`OUT_W`: packed as imaginary part (zero) in the upper half and the sign-extended real sample in the lower half.
- `m_axis_tvalid`, out, 1: output beat valid.
- `m_axis_tready`, in, 1: FFT accepts the beat.
- `m_axis_tlast`, out, 1: marks the last beat of a frame.
- `overflow`, out, 1: one-cycle pulse for each valid sample dropped.
- `frame_cnt`, out, 16: number of frames fully sent. Wraps at 2^16.

## Operation
- Storage has two banks, each `FRAME_LEN` deep, with a `full[1:0]` flag per bank.
- Write FSM has three states: IDLE, FILL, DROP.
  - IDLE: go to FILL on `capture_en`=1 when `full[wr_bank]`=0; set `wr_addr`=0.
  - FILL: each cycle with `data_valid`, write to `wr_bank` at `wr_addr` and increment `wr_addr`.
    - On the write at `wr_addr`=`FRAME_LEN`-1: set `full[wr_bank]`, toggle `wr_bank`, reset `wr_addr` to 0.
    - Next state after that write: FILL if the new bank is empty, otherwise DROP.
  - DROP: each valid sample is discarded with `overflow` pulsed. Go to FILL with `wr_addr`=0 in the cycle after `full[wr_bank]` clears. Frames always start at address 0; partial frames are never emitted.
  - `capture_en`=0 in FILL or DROP: return to IDLE on the next edge. The partial frame is abandoned and `wr_addr` is cleared. Full banks are unaffected and are still streamed.
- Read side:
  - Always reads bank `rd_bank`, starting at 0, once `full[rd_bank]`=1.
  - Advances one beat per `tvalid`&`tready` handshake.
  - On the `tlast` handshake: clear `full[rd_bank]`, toggle `rd_bank`, increment `frame_cnt`.
- If the write side sets `full[b]` and the read side clears `full[~b]` in the same cycle, both take effect. Set and clear never target the same bank in one cycle.
- Sign extension: the lower half of `tdata` is `data_in` replicated in its MSB up to `OUT_W`. The upper `OUT_W` bits are 0.

## Timing
- Values in and after reset: `tvalid`=0, `tlast`=0, `tdata`=0, `overflow`=0, `frame_cnt`=0, `full`=00, `wr_bank`=`rd_bank`=0, write FSM in IDLE.
- RAM is simple dual-port with a 1-cycle registered read.
- A 2-entry output skid/prefetch register holds `tdata`/`tlast` stable while `tvalid`=1 and `tready`=0. AXI-Stream rules apply: once `tvalid` rises it stays high until the handshake.
- Latency: `tvalid` rises no later than 3 cycles after the edge that sets `full[rd_bank]`.
- Throughput: 1 beat/cycle while `tready`=1, with no bubbles inside a frame. Back-to-back frames may have a gap of at most 2 cycles.
- `overflow` asserts in the same cycle as the dropped sample's edge plus 1 (registered).
- Reset asserted mid-frame: all state clears immediately (async). Post-reset output begins only with a fresh, complete frame.

## Structure
- Shared package `fft_pkg`:
  - `FRAME_LEN` and `OUT_W` defaults.
  - Write-FSM state enum (IDLE/FILL/DROP).
  - A `pack_tdata` function (sign-extend plus zero imaginary part).
- One sub-module, `pingpong_ram`: simple dual-port, depth 2*`FRAME_LEN`, width `DATA_W`. The address is {bank, addr}. Registered read, inferable as block RAM.
- Top level holds both FSMs, the flags and the skid register.

## Test plan
All scenarios use `FRAME_LEN`=8.
- **Continuous ramp:** `data_valid`=1, `tready`=1, `data_in`=0,1,2… → frames 0..7, 8..15 out in order; `tlast` on values 7 and 15; no `overflow`; `frame_cnt`=2.
- **Negative sample:** `data_in`=-5 (14'h3FFB) → `tdata`=32'h0000_FFFB.
- **Backpressure:** `tready` toggles 1/0 each cycle → every value is seen exactly once; `tdata` holds while stalled; no `overflow`.
- **Overflow:** `tready`=0 for 30 cycles with continuous input → two full banks; samples 16..29 produce 14 `overflow` pulses. After `tready`=1, output is 0..7, 8..15, then a frame starting at address 0 with the first sample accepted after bank 0 frees.
- **Abort and reset:** `capture_en` drops after 5 samples → no output for that partial frame. `rst` pulsed mid-stream → `tvalid`=0 at once; the next frame starts clean with `frame_cnt`=0.
